pico_peri_regs: RTL and testbench
=================================

Name: pico_peri_regs

Overview:
Parametrised peripheral register block for the pico-squared SoC, decoded at 0x1000_00xx on the picorv32 native bus. It generalises the fixed 8-bit GPIO / 3-LED / UART register set with:
- configurable GPIO width and synchronised inputs
- NUM_PWM duty-cycle LED channels
- a UART TX FIFO that drains into the existing uart_tx, so software no longer polls tx_busy per byte
- clean read-side-effect handling of the UART RX register

Parameters:
GPIO_W, 8, width of GPIO output and input ports (1..32)
NUM_PWM, 3, number of PWM LED channels (1..8)
PWM_BITS, 8, duty and counter width (2..16)
TXF_DEPTH, 8, TX FIFO entries; power of two, 2..256

Ports:
cpu_clk  in  1  sole clock
rstn  in  1  asynchronous active-low reset
sel  in  1  bus select (mem_valid && addr[31:28]==1)
addr  in  8  byte address, addr[7:0]
wstrb  in  4  write strobes; 0 = read
wdata  in  32  write data
rdata  out  32  read data, combinational
ready  out  1  bus ready
gpio_out  out  GPIO_W  output register
gpio_in  in  GPIO_W  asynchronous pins
pwm_out  out  NUM_PWM  PWM LED drive, to SB_RGBA_DRV PWM inputs
uart_tx_en  out  1  one-cycle start pulse to uart_tx
uart_tx_data  out  8  byte for uart_tx, valid with uart_tx_en
uart_tx_busy  in  1  from uart_tx
uart_rx_valid  in  1  from uart_rx
uart_rx_data  in  8  from uart_rx
uart_rx_read  out  1  one-cycle pop pulse to uart_rx

Behaviour:
- Reset: single clock cpu_clk; rstn asynchronous active-low, clears every flop.
  - Reset values: gpio_out=0, pwm_out=0, uart_tx_en=0, uart_rx_read=0, FIFO empty, ovf=0, enables=0, duties all-ones.
  - rstn assertion mid-transfer flushes the FIFO and drops any pending tx_en.
- Bus handshake: ready = sel (same cycle). A write commits on the cpu_clk edge where sel && |wstrb. Only wstrb[0] gates byte 0; wider registers use their strobes per byte.
- Unmapped addresses read 0 and ignore writes.
- Register map (word offsets):
  - 0x00 OUT rw [GPIO_W-1:0].
  - 0x04 IN ro. gpio_in passes through a 2-flop synchroniser; reads return the second stage.
  - 0x08 LED rw [NUM_PWM-1:0], per-channel enable.
  - 0x10 UART data.
    - Write pushes wdata[7:0] into the TX FIFO.
    - Read returns {24'b0, uart_rx_data}. uart_rx_read pulses one cycle only on a read (sel && wstrb==0).
  - 0x14 STATUS.
    - bit0 tx_full, bit1 uart_rx_valid, bit2 tx_empty (FIFO empty && !uart_tx_busy), bit3 tx_ovf sticky.
    - [16+:9] FIFO level.
    - Writing bit3=1 clears tx_ovf.
  - 0x20+4*i DUTY[i] rw [PWM_BITS-1:0], for i < NUM_PWM.
- TX FIFO: circular buffer with log2(TXF_DEPTH)+1-bit pointers.
  - Push to a full FIFO: byte dropped, tx_ovf set.
- Drain FSM, states IDLE → START → WAIT:
  - IDLE: if FIFO non-empty and !uart_tx_busy, go to START.
  - START: assert uart_tx_en with uart_tx_data = head, pop head, go to WAIT.
  - WAIT: hold one cycle (covers uart_tx busy latency), then return to IDLE.
  - Simultaneous push and pop: both occur, level unchanged.
  - Push when full with a pop in the same cycle: the push is accepted.
- PWM: free-running PWM_BITS counter wrapping at 2^PWM_BITS-1.
  - pwm_out[i] is registered: enable[i] && (cnt < duty[i]).
  - duty=0 gives constantly low; duty=all-ones gives high for 2^PWM_BITS-1 of 2^PWM_BITS cycles.
  - This reset default keeps legacy on/off LED writes working.

Optional Feature:
PERI_EDGE_CAPTURE_EN
- Defined:
  - Register 0x18 EDGE rw1c [GPIO_W-1:0] latches rising edges of the synchronised gpio_in. The edge is sampled as stage2 && !stage3; a third flop is added.
  - Writing 1 clears a bit. If a set and a clear coincide on the same bit, the set wins.
  - STATUS bit4 = |EDGE.
- Undefined: 0x18 reads 0, STATUS bit4 reads 0, no extra flops.

Test Plan:
- Reset: rstn low for 3 cycles mid-drain → tx_en=0; STATUS reads 0x0000_0004; gpio_out=0; DUTY0 reads 0xFF.
- Write 0xA5 to 0x00; gpio_in=0x3C → OUT reads 0xA5; IN reads 0x3C two cycles after the pin change, not earlier.
- Push 9 bytes 0x01..0x09 with DEPTH=8 and uart_tx_busy held high → level 8, tx_full=1, tx_ovf=1. Release busy, modelling 10-cycle busy after each tx_en → bytes 0x01..0x08 emitted in order, each tx_en exactly one cycle. Then write 0x08 to 0x14 → ovf cleared.
- Read 0x10 with uart_rx_valid=1, data 0x5A → rdata=0x5A, uart_rx_read single pulse. Write to 0x10 → no rx_read pulse.
- LED=0b001, DUTY0=64 → pwm_out[0] high 64 of every 256 cycles. DUTY0=0 → never high. LED=0 → all pwm_out low.
- With PERI_EDGE_CAPTURE_EN: pulse gpio_in[2] for 1 cycle wide enough to be sampled → EDGE=0x04, STATUS bit4=1. Write 0x04 to 0x18 → EDGE=0. Rising edge on the same cycle as the clear → bit stays set.

Source files
------------

// File: rtl/pico_peri_regs.sv
// Peripheral register block at 0x1000_00xx: GPIO, PWM LEDs, UART TX FIFO with drain FSM, UART RX access.
// Optional GPIO rising-edge capture register at 0x18 when PERI_EDGE_CAPTURE_EN is defined.
module pico_peri_regs #(
  parameter int GPIO_W    = 8,
  parameter int NUM_PWM   = 3,
  parameter int PWM_BITS  = 8,
  parameter int TXF_DEPTH = 8
) (
  input  logic                cpu_clk,
  input  logic                rstn,
  input  logic                sel,
  input  logic [7:0]          addr,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic [GPIO_W-1:0]   gpio_out,
  input  logic [GPIO_W-1:0]   gpio_in,
  output logic [NUM_PWM-1:0]  pwm_out,
  output logic                uart_tx_en,
  output logic [7:0]          uart_tx_data,
  input  logic                uart_tx_busy,
  input  logic                uart_rx_valid,
  input  logic [7:0]          uart_rx_data,
  output logic                uart_rx_read
);

  localparam int AW = (TXF_DEPTH > 1) ? $clog2(TXF_DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT} state_t;

  logic [5:0]  w_widx;
  logic        w_wr, w_rd;
  logic [31:0] w_bmask;
  logic        w_wr_out, w_wr_led, w_wr_stat, w_push_req, w_push, w_pop;
  logic [AW:0] w_level;
  logic [8:0]  w_level9;
  logic        w_full, w_empty;
  logic        w_edge_any;
  logic [GPIO_W-1:0] w_edge_word;
  state_t      r_state, w_state_nxt;

  logic [GPIO_W-1:0]   r_gpio_out, r_gpio_s1, r_gpio_s2;
  logic [NUM_PWM-1:0]  r_led_en, r_pwm_out;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_duty [NUM_PWM];
  logic [7:0]          r_txf_mem [TXF_DEPTH];
  logic [AW:0]         r_wp, r_rp;
  logic                r_ovf, r_rx_read;

  assign w_widx     = addr[7:2];
  assign w_wr       = sel && (wstrb != 4'b0);
  assign w_rd       = sel && (wstrb == 4'b0);
  assign w_bmask    = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign w_wr_out   = w_wr && (w_widx == 6'd0);
  assign w_wr_led   = w_wr && (w_widx == 6'd2) && wstrb[0];
  assign w_wr_stat  = w_wr && (w_widx == 6'd5) && wstrb[0];
  assign w_push_req = w_wr && (w_widx == 6'd4) && wstrb[0];

  assign ready        = sel;
  assign gpio_out     = r_gpio_out;
  assign pwm_out      = r_pwm_out;
  assign uart_rx_read = r_rx_read;

  always_ff @(posedge cpu_clk or negedge rstn) begin
    if (!rstn) begin
      r_gpio_out <= '0;
      r_gpio_s1  <= '0;
      r_gpio_s2  <= '0;
      r_led_en   <= '0;
      r_pwm_cnt  <= '0;
      r_pwm_out  <= '0;
      r_rx_read  <= 1'b0;
    end else begin
      if (w_wr_out)
        r_gpio_out <= (r_gpio_out & ~w_bmask[GPIO_W-1:0]) | (wdata[GPIO_W-1:0] & w_bmask[GPIO_W-1:0]);
      r_gpio_s1 <= gpio_in;
      r_gpio_s2 <= r_gpio_s1;
      if (w_wr_led)
        r_led_en <= wdata[NUM_PWM-1:0];
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      for (int i = 0; i < NUM_PWM; i++)
        r_pwm_out[i] <= r_led_en[i] && (r_pwm_cnt < r_duty[i]);
      r_rx_read <= w_rd && (w_widx == 6'd4);
    end
  end

  // All-ones duty by default so plain LED enable writes behave as on/off.
  for (genvar g = 0; g < NUM_PWM; g++) begin : g_duty
    always_ff @(posedge cpu_clk or negedge rstn) begin
      if (!rstn)
        r_duty[g] <= '1;
      else if (w_wr && (w_widx == 6'(8 + g)))
        r_duty[g] <= (r_duty[g] & ~w_bmask[PWM_BITS-1:0]) | (wdata[PWM_BITS-1:0] & w_bmask[PWM_BITS-1:0]);
    end
  end

  assign w_level  = r_wp - r_rp;
  assign w_level9 = 9'(w_level);
  assign w_full   = (w_level == (AW+1)'(TXF_DEPTH));
  assign w_empty  = (r_wp == r_rp);
  assign w_pop    = (r_state == ST_START);
  assign w_push   = w_push_req && (!w_full || w_pop);
  assign uart_tx_data = r_txf_mem[r_rp[AW-1:0]];

  always_ff @(posedge cpu_clk or negedge rstn) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i < TXF_DEPTH; i++)
        r_txf_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_txf_mem[r_wp[AW-1:0]] <= wdata[7:0];
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_push_req && !w_push)
        r_ovf <= 1'b1;
      else if (w_wr_stat && wdata[3])
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge cpu_clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // WAIT gives uart_tx one cycle to raise busy before IDLE looks at it again.
  always_comb begin
    w_state_nxt = r_state;
    uart_tx_en  = 1'b0;
    case (r_state)
      ST_IDLE:  if (!w_empty && !uart_tx_busy) w_state_nxt = ST_START;
      ST_START: begin
        uart_tx_en  = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef PERI_EDGE_CAPTURE_EN
  logic [GPIO_W-1:0] r_gpio_s3, r_edge, w_rise, w_clr;

  assign w_rise = r_gpio_s2 & ~r_gpio_s3;
  assign w_clr  = (w_wr && (w_widx == 6'd6)) ? (wdata[GPIO_W-1:0] & w_bmask[GPIO_W-1:0]) : '0;

  // Set dominates a coincident write-1-to-clear.
  always_ff @(posedge cpu_clk or negedge rstn) begin
    if (!rstn) begin
      r_gpio_s3 <= '0;
      r_edge    <= '0;
    end else begin
      r_gpio_s3 <= r_gpio_s2;
      r_edge    <= (r_edge & ~w_clr) | w_rise;
    end
  end

  assign w_edge_word = r_edge;
  assign w_edge_any  = |r_edge;
`else
  assign w_edge_word = '0;
  assign w_edge_any  = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    case (w_widx)
      6'd0: rdata[GPIO_W-1:0]  = r_gpio_out;
      6'd1: rdata[GPIO_W-1:0]  = r_gpio_s2;
      6'd2: rdata[NUM_PWM-1:0] = r_led_en;
      6'd4: rdata[7:0]         = uart_rx_data;
      6'd5: begin
        rdata[0]     = w_full;
        rdata[1]     = uart_rx_valid;
        rdata[2]     = w_empty && !uart_tx_busy;
        rdata[3]     = r_ovf;
        rdata[4]     = w_edge_any;
        rdata[24:16] = w_level9;
      end
      6'd6: rdata[GPIO_W-1:0] = w_edge_word;
      default: ;
    endcase
    for (int i = 0; i < NUM_PWM; i++)
      if (w_widx == 6'(8 + i)) rdata[PWM_BITS-1:0] = r_duty[i];
  end

endmodule

// File: tb/tb_pico_peri_regs.sv
// Directed bench for pico_peri_regs with default parameters; edge-capture checks follow PERI_EDGE_CAPTURE_EN.
module tb_pico_peri_regs;
  logic        cpu_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  addr = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_in = '0;
  logic [2:0]  pwm_out;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy = 1'b0;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_read;

  pico_peri_regs dut (
    .cpu_clk(cpu_clk), .rstn(rstn), .sel(sel), .addr(addr), .wstrb(wstrb),
    .wdata(wdata), .rdata(rdata), .ready(ready), .gpio_out(gpio_out),
    .gpio_in(gpio_in), .pwm_out(pwm_out), .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
    .uart_rx_read(uart_rx_read)
  );

  always #5 cpu_clk = ~cpu_clk;

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // uart_tx model: busy for 10 cycles after each start pulse; also logs bytes and rx pops.
  int         busy_cnt = 0;
  bit         force_busy = 0;
  logic [7:0] tx_q[$];
  int         tx_cnt = 0;
  int         wide_en = 0;
  bit         prev_en = 0;
  int         rx_cnt = 0;

  always @(negedge cpu_clk) begin
    if (!rstn) busy_cnt = 0;
    else if (uart_tx_en) begin
      busy_cnt = 10;
      tx_q.push_back(uart_tx_data);
      tx_cnt++;
      if (prev_en) wide_en++;
    end else if (busy_cnt > 0) busy_cnt--;
    prev_en = uart_tx_en;
    uart_tx_busy = force_busy || (busy_cnt != 0);
    if (uart_rx_read) rx_cnt++;
  end

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    sel = 1'b1; addr = a; wdata = d; wstrb = s;
    @(negedge cpu_clk);
    sel = 1'b0; wstrb = '0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    sel = 1'b1; addr = a; wstrb = '0;
    #1 d = rdata;
    @(negedge cpu_clk);
    sel = 1'b0;
  endtask

  logic [31:0] rd;
  int en_seen, c0, c1, cany;

  initial begin
    repeat (3) @(negedge cpu_clk);
    rstn = 1'b1;
    @(negedge cpu_clk);
    bus_rd(8'h14, rd); check_val("rst_status", rd, 32'h0000_0004);
    bus_rd(8'h20, rd); check_val("rst_duty0", rd, 32'h0000_00FF);
    check_val("rst_gpio_out", {24'b0, gpio_out}, 32'h0);

    // reset in the middle of a drain
    bus_wr(8'h00, 32'h77, 4'h1);
    bus_wr(8'h10, 32'h11, 4'h1);
    bus_wr(8'h10, 32'h22, 4'h1);
    bus_wr(8'h10, 32'h33, 4'h1);
    for (int k = 0; k < 50 && tx_cnt < 1; k++) @(negedge cpu_clk);
    check_val("drain_first_byte", (tx_q.size() > 0) ? {24'b0, tx_q[0]} : 32'hDEAD, 32'h11);
    rstn = 1'b0;
    en_seen = 0;
    repeat (3) begin
      @(negedge cpu_clk);
      if (uart_tx_en) en_seen++;
    end
    check_val("rst_tx_en", en_seen, 0);
    check_val("rst_gpio_out2", {24'b0, gpio_out}, 32'h0);
    rstn = 1'b1;
    repeat (2) @(negedge cpu_clk);
    bus_rd(8'h14, rd); check_val("rst_status2", rd, 32'h0000_0004);
    bus_rd(8'h20, rd); check_val("rst_duty0_2", rd, 32'h0000_00FF);
    repeat (20) @(negedge cpu_clk);
    check_val("rst_flushed", tx_cnt, 1);

    // GPIO
    bus_wr(8'h00, 32'hA5, 4'h1);
    check_val("gpio_out_pin", {24'b0, gpio_out}, 32'hA5);
    bus_rd(8'h00, rd); check_val("out_rd", rd, 32'hA5);
    bus_wr(8'h00, 32'hFFFF_FF5A, 4'b1110);
    bus_rd(8'h00, rd); check_val("out_strb", rd, 32'hA5);
    bus_wr(8'h0C, 32'hFFFF_FFFF, 4'hF);
    bus_rd(8'h0C, rd); check_val("unmapped_0c", rd, 32'h0);
    bus_rd(8'h2C, rd); check_val("unmapped_2c", rd, 32'h0);
    gpio_in = 8'h3C;
    bus_rd(8'h04, rd); check_val("in_early0", rd, 32'h0);
    bus_rd(8'h04, rd); check_val("in_early1", rd, 32'h0);
    bus_rd(8'h04, rd); check_val("in_sync", rd, 32'h3C);
    repeat (4) @(negedge cpu_clk);
    bus_wr(8'h18, 32'hFF, 4'h1);

    // TX FIFO overflow and ordered drain
    tx_q.delete(); tx_cnt = 0; wide_en = 0;
    force_busy = 1;
    @(negedge cpu_clk);
    for (int i = 1; i <= 9; i++) bus_wr(8'h10, i, 4'h1);
    bus_rd(8'h14, rd); check_val("ovf_status", rd, 32'h0008_0009);
    check_val("held_no_tx", tx_cnt, 0);
    force_busy = 0;
    for (int k = 0; k < 400 && tx_cnt < 8; k++) @(negedge cpu_clk);
    check_val("drain_cnt", tx_cnt, 8);
    for (int i = 0; i < 8; i++)
      check_val($sformatf("tx_byte%0d", i), (i < tx_q.size()) ? {24'b0, tx_q[i]} : 32'hDEAD, i + 1);
    check_val("tx_en_width", wide_en, 0);
    repeat (15) @(negedge cpu_clk);
    bus_rd(8'h14, rd); check_val("drained_status", rd, 32'h0000_000C);
    bus_wr(8'h14, 32'h08, 4'h1);
    bus_rd(8'h14, rd); check_val("ovf_clear", rd, 32'h0000_0004);

    // UART RX
    uart_rx_valid = 1'b1; uart_rx_data = 8'h5A; rx_cnt = 0;
    bus_rd(8'h10, rd); check_val("rx_data", rd, 32'h5A);
    repeat (3) @(negedge cpu_clk);
    check_val("rx_read_pulse", rx_cnt, 1);
    rx_cnt = 0;
    bus_rd(8'h14, rd); check_val("rx_status", rd, 32'h0000_0006);
    bus_wr(8'h10, 32'h99, 4'h1);
    repeat (3) @(negedge cpu_clk);
    check_val("rx_no_pulse", rx_cnt, 0);
    uart_rx_valid = 1'b0;

    // PWM
    bus_wr(8'h08, 32'hFF, 4'h1);
    bus_rd(8'h08, rd); check_val("led_mask", rd, 32'h7);
    bus_wr(8'h08, 32'h1, 4'h1);
    bus_wr(8'h20, 32'h40, 4'h1);
    bus_rd(8'h20, rd); check_val("duty0_rd", rd, 32'h40);
    repeat (3) @(negedge cpu_clk);
    c0 = 0; c1 = 0;
    repeat (256) begin @(negedge cpu_clk); c0 += pwm_out[0]; c1 += pwm_out[1]; end
    check_val("pwm_duty64", c0, 64);
    check_val("pwm_ch1_off", c1, 0);
    bus_wr(8'h08, 32'h2, 4'h1);
    repeat (3) @(negedge cpu_clk);
    c1 = 0;
    repeat (256) begin @(negedge cpu_clk); c1 += pwm_out[1]; end
    check_val("pwm_duty_ff", c1, 255);
    bus_wr(8'h20, 32'h0, 4'h1);
    bus_wr(8'h08, 32'h3, 4'h1);
    repeat (3) @(negedge cpu_clk);
    c0 = 0;
    repeat (256) begin @(negedge cpu_clk); c0 += pwm_out[0]; end
    check_val("pwm_duty0", c0, 0);
    bus_wr(8'h08, 32'h0, 4'h1);
    repeat (3) @(negedge cpu_clk);
    cany = 0;
    repeat (256) begin @(negedge cpu_clk); if (pwm_out != 3'b0) cany++; end
    check_val("pwm_all_off", cany, 0);

    // GPIO edge capture
    gpio_in = 8'h00;
    repeat (4) @(negedge cpu_clk);
    bus_wr(8'h18, 32'hFF, 4'h1);
`ifdef PERI_EDGE_CAPTURE_EN
    bus_rd(8'h18, rd); check_val("edge_clr0", rd, 32'h0);
    gpio_in = 8'h04;
    @(negedge cpu_clk);
    gpio_in = 8'h00;
    repeat (4) @(negedge cpu_clk);
    bus_rd(8'h18, rd); check_val("edge_set", rd, 32'h04);
    bus_rd(8'h14, rd); check_val("edge_stat_bit4", (rd >> 4) & 32'h1, 32'h1);
    bus_wr(8'h18, 32'h04, 4'h1);
    bus_rd(8'h18, rd); check_val("edge_clr", rd, 32'h0);
    gpio_in = 8'h04;
    @(negedge cpu_clk);
    gpio_in = 8'h00;
    @(negedge cpu_clk);
    bus_wr(8'h18, 32'h04, 4'h1);
    repeat (2) @(negedge cpu_clk);
    bus_rd(8'h18, rd); check_val("edge_set_wins", rd, 32'h04);
`else
    gpio_in = 8'h04;
    @(negedge cpu_clk);
    gpio_in = 8'h00;
    repeat (4) @(negedge cpu_clk);
    bus_rd(8'h18, rd); check_val("edge_absent", rd, 32'h0);
    bus_rd(8'h14, rd); check_val("edge_stat_absent", (rd >> 4) & 32'h1, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
